// File: rtl/adc_scan_if.sv
// SAR converter / oversampling accumulator bus between the scan controller
// (master) and the analog front end (slave).
interface adc_scan_if #(
  parameter int CH_W = 2
) ();
  logic            sar_start;
  logic            sar_done;
  logic            osr_done;
  logic [15:0]     osr_data;
  logic            osr_clr_n;
  logic [2:0]      osr_mode_out;
  logic [CH_W-1:0] mux_sel;

  modport master (output sar_start, osr_clr_n, osr_mode_out, mux_sel,
                  input  sar_done, osr_done, osr_data);
  modport slave  (input  sar_start, osr_clr_n, osr_mode_out, mux_sel,
                  output sar_done, osr_done, osr_data);
endinterface

// File: rtl/adc_scan_ctrl.sv
// Periodic scan of enabled ADC channels: mux select, accumulator clear, SAR
// start pulses until the oversampled result is ready, then per-channel store.
module adc_scan_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic [2:0]        osr_mode_i,
  input  logic [15:0]       period_i,
  adc_scan_if.master        adc,
  input  logic [CH_W-1:0]   rd_sel_i,
  output logic [15:0]       rd_data_o,
  output logic [NUM_CH-1:0] valid_o,
  output logic              scan_done_o,
  output logic              irq_o,
  input  logic              irq_clr_i,
  output logic              overrun_o,
  output logic              timeout_err_o
);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CLEAR, S_SETTLE, S_START, S_WAIT, S_CHECK, S_STORE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             per_q, per_d;
  logic [CH_W-1:0]         ch_q, ch_d, mux_q, mux_d;
  logic [2:0]              mode_q, mode_d;
  logic [NUM_CH-1:0]       pend_q, pend_d, valid_q, valid_d, nxt_pend;
  logic [NUM_CH-1:0][15:0] res_q, res_d;
  logic [15:0]             rd_q, rd_d;
  logic [2:0]              sync_q;
  logic                    seen_q, seen_d, stop_q, stop_d;
  logic                    irq_q, ovr_q, tmo_q;
  logic                    tick, rise, clr_n, advance, tmo_set, done_pulse;

  function automatic logic [CH_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) first_ch = CH_W'(i);
  endfunction

  assign tick  = en_i && ((period_i == 16'd0) || (per_q == period_i - 16'd1));
  assign per_d = (!en_i || tick) ? 16'd0 : per_q + 16'd1;

  // osr_done crosses in through two flops; the third flop only feeds the edge detect
  assign rise     = sync_q[1] & ~sync_q[2];
  assign clr_n    = (state_q != S_CLEAR);
  assign seen_d   = clr_n & (seen_q | rise);
  assign nxt_pend = pend_q & ~(NUM_CH'(1) << ch_q);
  assign rd_d     = (int'(rd_sel_i) < NUM_CH) ? res_q[rd_sel_i] : 16'd0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    mux_d      = mux_q;
    mode_d     = mode_q;
    pend_d     = pend_q;
    valid_d    = valid_q;
    res_d      = res_q;
    stop_d     = stop_q | (!en_i && (state_q != S_IDLE));
    advance    = 1'b0;
    tmo_set    = 1'b0;
    done_pulse = 1'b0;
    unique case (state_q)
      S_IDLE: if (tick && (ch_mask_i != '0)) begin
        pend_d  = ch_mask_i;
        valid_d = '0;
        ch_d    = first_ch(ch_mask_i);
        mux_d   = first_ch(ch_mask_i);
        mode_d  = osr_mode_i;
        stop_d  = 1'b0;
        state_d = S_SELECT;
      end
      S_SELECT: begin
        cnt_d   = ONE;
        state_d = S_CLEAR;
      end
      S_CLEAR:
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(SETTLE - 1);
          state_d = S_SETTLE;
        end else cnt_d = cnt_q - ONE;
      S_SETTLE:
        if (cnt_q == '0) state_d = S_START;
        else cnt_d = cnt_q - ONE;
      S_START: begin
        cnt_d   = CNT_W'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT:
        if (adc.sar_done) begin
          cnt_d   = CNT_W'(2);
          state_d = S_CHECK;
        end else if (cnt_q == '0) begin
          tmo_set = 1'b1;
          advance = 1'b1;
        end else cnt_d = cnt_q - ONE;
      S_CHECK:
        if (cnt_q == '0) state_d = seen_q ? S_STORE : S_START;
        else cnt_d = cnt_q - ONE;
      S_STORE: begin
        res_d[ch_q]   = adc.osr_data;
        valid_d[ch_q] = 1'b1;
        advance       = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A scan aborted by en never reports completion, even on its last channel
    if (advance) begin
      pend_d = nxt_pend;
      if (!stop_q && en_i && (nxt_pend != '0)) begin
        ch_d    = first_ch(nxt_pend);
        mux_d   = first_ch(nxt_pend);
        state_d = S_SELECT;
      end else begin
        state_d    = S_IDLE;
        done_pulse = !stop_q && (nxt_pend == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      ch_q    <= '0;
      mux_q   <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      valid_q <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      sync_q  <= '0;
      seen_q  <= 1'b0;
      stop_q  <= 1'b0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      ch_q    <= ch_d;
      mux_q   <= mux_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      sync_q  <= {sync_q[1:0], adc.osr_done};
      seen_q  <= seen_d;
      stop_q  <= stop_d;
      irq_q   <= done_pulse | (irq_q & ~irq_clr_i);
      ovr_q   <= (tick && (state_q != S_IDLE)) | (ovr_q & ~irq_clr_i);
      tmo_q   <= tmo_set | (tmo_q & ~irq_clr_i);
    end
  end

  assign adc.sar_start    = (state_q == S_START);
  assign adc.osr_clr_n    = clr_n;
  assign adc.osr_mode_out = mode_q;
  assign adc.mux_sel      = mux_q;
  assign rd_data_o        = rd_q;
  assign valid_o          = valid_q;
  assign scan_done_o      = done_pulse;
  assign irq_o            = irq_q;
  assign overrun_o        = ovr_q;
  assign timeout_err_o    = tmo_q;
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl: SAR/accumulator model, scan scoreboard
// checked on scan_done, plus direct checks of latency, flags and readback.
module tb_adc_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, en, irq_clr, scan_done, irq, overrun, timeout_err;
  logic [3:0]  ch_mask, valid;
  logic [2:0]  osr_mode;
  logic [15:0] period, rd_data;
  logic [1:0]  rd_sel;

  adc_scan_if #(.CH_W(2)) adc ();

  adc_scan_ctrl #(.NUM_CH(4), .CH_W(2), .SETTLE(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .ch_mask_i(ch_mask),
    .osr_mode_i(osr_mode), .period_i(period), .adc(adc), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data), .valid_o(valid), .scan_done_o(scan_done),
    .irq_o(irq), .irq_clr_i(irq_clr), .overrun_o(overrun),
    .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    int         starts;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   blk_ch = -1;
  int   dly = 0;
  int   acc_n = 0;
  int   mon_nstart = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] v, input int n);
    exp_t e;
    e.valid = v;
    e.starts = n;
    sb.push_back(e);
  endtask

  task automatic rd_chk(input logic [1:0] ch, input logic [15:0] exp, input string name);
    rd_sel = ch;
    repeat (2) @(negedge clk);
    chk(name, rd_data, exp);
  endtask

  task automatic pulse_clr;
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (scan_done) break;
    end
    en = 1'b0;
    checks++;
    if (i == budget) begin
      errors++;
      $display("FAIL %s: no scan_done within %0d cycles", name, budget);
    end
  endtask

  // SAR answers 5 cycles after each start; accumulator finishes after 4^mode samples
  always @(negedge clk) begin
    adc.sar_done = 1'b0;
    if (!rst_n) begin
      dly = 0;
      acc_n = 0;
      adc.osr_done = 1'b0;
      adc.osr_data = 16'h0;
    end else begin
      if (!adc.osr_clr_n) begin
        acc_n = 0;
        adc.osr_done = 1'b0;
      end
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          adc.sar_done = 1'b1;
          acc_n++;
          if (acc_n == (1 << (2 * int'(adc.osr_mode_out)))) begin
            adc.osr_done = 1'b1;
            adc.osr_data = 16'(32'h1000 * (int'(adc.mux_sel) + 1) + acc_n);
          end
        end
      end
      if (adc.sar_start && (int'(adc.mux_sel) != blk_ch)) dly = 5;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (adc.sar_start) mon_nstart++;
      if (scan_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_scan_done: scan_done seen, none expected");
        end else begin
          e = sb.pop_front();
          chk("scan_starts", mon_nstart, e.starts);
          @(negedge clk);
          chk("scan_valid", valid, e.valid);
          chk("scan_irq", irq, 1);
        end
        mon_nstart = 0;
      end
      if (!rst_n || !en) mon_nstart = 0;
    end
  end

  initial begin : stim
    int first, clr_low, t_st, t_to, extra;
    logic got;
    rst_n = 1'b0; en = 1'b0; irq_clr = 1'b0; ch_mask = '0;
    osr_mode = '0; period = '0; rd_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_sar_start", adc.sar_start, 0);
    chk("rst_clr_n", adc.osr_clr_n, 1);
    chk("rst_mux", adc.mux_sel, 0);
    chk("rst_mode", adc.osr_mode_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_flags", {scan_done, irq, overrun, timeout_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single scan, bypass mode
    ch_mask = 4'b0101; osr_mode = 3'd0; period = 16'd100;
    push_exp(4'b0101, 2);
    en = 1'b1;
    wait_done("single_scan", 400);
    repeat (2) @(negedge clk);
    chk("s1_irq", irq, 1);
    chk("s1_overrun", overrun, 0);
    chk("s1_timeout", timeout_err, 0);
    rd_chk(2'd0, 16'h1001, "s1_rd0");
    rd_chk(2'd2, 16'h3001, "s1_rd2");
    rd_chk(2'd1, 16'h0000, "s1_rd1");

    // oversampling x16, back-to-back period: check tick-to-start latency
    ch_mask = 4'b0001; osr_mode = 3'b010; period = 16'd0;
    push_exp(4'b0001, 16);
    first = 0; clr_low = 0; got = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 600 && !got; i++) begin
      @(negedge clk);
      if (first == 0 && !adc.osr_clr_n) clr_low++;
      if (first == 0 && adc.sar_start) first = i;
      if (scan_done) begin got = 1'b1; en = 1'b0; end
    end
    chk("s2_scan_done", got, 1);
    chk("s2_first_start", first, 8);
    chk("s2_clr_low", clr_low, 2);
    repeat (2) @(negedge clk);
    chk("s2_overrun", overrun, 1);
    rd_chk(2'd0, 16'h1010, "s2_rd0");
    pulse_clr();
    chk("s2_irq_clr", {irq, overrun}, 0);

    // overrun: ticks every 10 cycles during a longer scan
    ch_mask = 4'b0011; osr_mode = 3'd0; period = 16'd10;
    push_exp(4'b0011, 2);
    en = 1'b1;
    wait_done("overrun_scan", 400);
    repeat (2) @(negedge clk);
    chk("s3_overrun", overrun, 1);
    chk("s3_timeout", timeout_err, 0);
    rd_chk(2'd1, 16'h2001, "s3_rd1");

    // timeout on channel 1, channel 2 still converted
    blk_ch = 1;
    ch_mask = 4'b0110; osr_mode = 3'd0; period = 16'd0;
    push_exp(4'b0100, 2);
    t_st = 0; t_to = 0; got = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 800 && !got; i++) begin
      @(negedge clk);
      if (t_st == 0 && adc.sar_start && adc.mux_sel == 2'd1) t_st = i;
      if (t_to == 0 && timeout_err) t_to = i;
      if (scan_done) begin got = 1'b1; en = 1'b0; end
    end
    blk_ch = -1;
    chk("s4_scan_done", got, 1);
    chk("s4_timeout_delay", t_to - t_st, 256);
    repeat (2) @(negedge clk);
    chk("s4_timeout", timeout_err, 1);
    rd_chk(2'd1, 16'h2001, "s4_rd1_kept");
    rd_chk(2'd2, 16'h3001, "s4_rd2");
    pulse_clr();
    chk("s4_clr_all", {irq, overrun, timeout_err}, 0);

    // en drop during channel 1 of a full-mask scan, mode x4
    ch_mask = 4'b1111; osr_mode = 3'd1; period = 16'd0;
    got = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (adc.sar_start && adc.mux_sel == 2'd1) begin got = 1'b1; en = 1'b0; end
    end
    chk("s5_ch1_start", got, 1);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (adc.sar_start) extra++;
    end
    chk("s5_extra_starts", extra, 3);
    chk("s5_valid", valid, 4'b0011);
    chk("s5_irq", irq, 0);
    rd_chk(2'd0, 16'h1004, "s5_rd0");
    rd_chk(2'd1, 16'h2004, "s5_rd1");
    rd_chk(2'd2, 16'h3001, "s5_rd2_kept");
    rd_chk(2'd3, 16'h0000, "s5_rd3_skipped");

    // async reset while waiting for sar_done
    ch_mask = 4'b0010; osr_mode = 3'd1; period = 16'd0;
    got = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (adc.sar_start) got = 1'b1;
    end
    chk("s6_start_seen", got, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_sar_start", adc.sar_start, 0);
    chk("s6_rst_clr_n", adc.osr_clr_n, 1);
    chk("s6_rst_mux_mode", {adc.mux_sel, adc.osr_mode_out}, 0);
    chk("s6_rst_valid_rd", {valid, rd_data}, 0);
    chk("s6_rst_flags", {scan_done, irq, overrun, timeout_err}, 0);
    repeat (2) @(negedge clk);
    push_exp(4'b0010, 4);
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      @(negedge clk);
      if (adc.sar_start) first = i;
    end
    chk("s6_first_start", first, 8);
    wait_done("post_reset_scan", 200);
    repeat (2) @(negedge clk);
    rd_chk(2'd1, 16'h2004, "s6_rd1");

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
